// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings for the HI/LO sequencing stage.
//   WIDTH   - datapath width (32)
//   op_e    - HI/LO-class operation codes from the execute stage
//   state_e - sequencer states
package hilo_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Codes 0..3 are the ops that launch multdiv.
    function automatic logic is_muldiv(input op_e o);
        return ~o[2];
    endfunction

    // MULT/MULTU are codes 0/1, DIV/DIVU are 2/3.
    function automatic logic is_mult(input op_e o);
        return ~o[1];
    endfunction

    // Signed variants are the even codes of the mult/div group.
    function automatic logic is_signed_op(input op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences HI/LO-class instructions in front of the serial
// multdiv unit and owns the architectural HI/LO registers.
//   clk, reset_b         - clock, async active-low reset
//   op_valid, op         - instruction presented by execute, op code
//   rs_val, rt_val       - operands (rs_val also feeds MTHI/MTLO)
//   stall                - hold the presented op this cycle
//   mf_data              - HI or LO for MFHI/MFLO (valid when !stall)
//   hi, lo, div0         - architectural state, last-divide-by-zero flag
//   md_*  (outputs)      - start pulse, mode and operands to multdiv
//   md_prodh/prodl/run/dbz - multdiv results and status
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             reset_b,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0,
    output logic             md_start,
    output logic             md_multdivb,
    output logic             md_signed,
    output logic [WIDTH-1:0] md_x,
    output logic [WIDTH-1:0] md_y,
    input  logic [WIDTH-1:0] md_prodh,
    input  logic [WIDTH-1:0] md_prodl,
    input  logic             md_run,
    input  logic             md_dbz
);

    state_e state;
    op_e    op_c;

    assign op_c = op_e'(op);

    // Any HI/LO-class op waits while an operation is in flight, including
    // the capture cycle, so MFHI/MFLO never sees a stale register.
    assign stall   = op_valid & (state != ST_IDLE);
    assign mf_data = (op_c == OP_MFHI) ? hi : lo;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= ST_IDLE;
            hi          <= '0;
            lo          <= '0;
            div0        <= 1'b0;
            md_start    <= 1'b0;
            md_multdivb <= 1'b0;
            md_signed   <= 1'b0;
            md_x        <= '0;
            md_y        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (is_muldiv(op_c)) begin
                            md_x        <= rs_val;
                            md_y        <= rt_val;
                            md_multdivb <= is_mult(op_c);
                            md_signed   <= is_signed_op(op_c);
                            md_start    <= 1'b1;
                            div0        <= 1'b0;
                            state       <= ST_START;
                        end else if (op_c == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op_c == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_START: begin
                    // multdiv samples start at this edge and raises run
                    // in the following cycle.
                    md_start <= 1'b0;
                    state    <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!md_run) begin
                        hi <= md_prodh;
                        lo <= md_prodl;
                        if (!md_multdivb)
                            div0 <= md_dbz;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    md_start <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
